// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: CPU-written command byte is framed (start, 8 data LSB first,
// odd parity, stop) and clocked out by the device; line ack checked, status exposed via data_out.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1500,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic        data_cs,
    input  logic        status_cs,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic        tx_active,
    inout  wire         ps2_clock,
    inout  wire         ps2_data
);

    localparam int MAX_COUNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [7:0]        shift, shift_n;
    logic              parity, parity_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic              data_low, data_low_n;
    logic              ack_error, ack_error_n;
    logic              timeout, timeout_n;
    logic              overrun, overrun_n;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic              clk_prev;
    logic              clk_now, dat_now, fall;
    logic              clk_drive_low, dat_drive_low;
    logic              unused_hi;

    assign unused_hi = ^data_in[31:8];

    // Synchronisers idle high so release of the lines never looks like an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_now;
        end
    end

    assign clk_now = clk_sync[SYNC_STAGES-1];
    assign dat_now = dat_sync[SYNC_STAGES-1];
    assign fall    = clk_prev & ~clk_now;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            parity    <= 1'b0;
            bit_idx   <= '0;
            data_low  <= 1'b0;
            ack_error <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift     <= shift_n;
            parity    <= parity_n;
            bit_idx   <= bit_idx_n;
            data_low  <= data_low_n;
            ack_error <= ack_error_n;
            timeout   <= timeout_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shift_n     = shift;
        parity_n    = parity;
        bit_idx_n   = bit_idx;
        data_low_n  = data_low;
        ack_error_n = ack_error;
        timeout_n   = timeout;
        overrun_n   = overrun;

        if (write && data_cs) begin
            if (state == IDLE) begin
                shift_n     = data_in[7:0];
                parity_n    = ~^data_in[7:0];
                cnt_n       = CW'(INHIBIT_CYCLES);
                state_n     = INHIBIT;
                ack_error_n = 1'b0;
                timeout_n   = 1'b0;
                overrun_n   = 1'b0;
            end else begin
                overrun_n = 1'b1;
            end
        end

        case (state)
            IDLE: ;
            INHIBIT: begin
                if (cnt == CW'(1)) begin
                    state_n    = DATA;
                    data_low_n = 1'b1;
                    cnt_n      = CW'(TIMEOUT_CYCLES);
                    bit_idx_n  = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                // Frame progress only on device clock edges; the watchdog runs in parallel.
                if (fall) begin
                    cnt_n = CW'(TIMEOUT_CYCLES);
                    case (state)
                        DATA: begin
                            data_low_n = ~shift[0];
                            shift_n    = {1'b0, shift[7:1]};
                            bit_idx_n  = bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state_n = PARITY;
                        end
                        PARITY: begin
                            data_low_n = ~parity;
                            state_n    = STOP;
                        end
                        STOP: begin
                            data_low_n = 1'b0;
                            state_n    = ACK;
                        end
                        ACK: begin
                            if (dat_now) ack_error_n = 1'b1;
                            state_n = WAIT_IDLE;
                        end
                        default: ;
                    endcase
                end else if (cnt == CW'(1)) begin
                    data_low_n = 1'b0;
                    timeout_n  = 1'b1;
                    state_n    = IDLE;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
                if (state == WAIT_IDLE && clk_now && dat_now) state_n = IDLE;
            end
        endcase
    end

    // Start bit goes onto the line during the final inhibit cycle, before the clock is released.
    assign clk_drive_low = (state == INHIBIT);
    assign dat_drive_low = data_low || ((state == INHIBIT) && (cnt == CW'(1)));

    assign ps2_clock = clk_drive_low ? 1'b0 : 1'bz;
    assign ps2_data  = dat_drive_low ? 1'b0 : 1'bz;

    assign tx_active      = (state != IDLE);
    assign data_out_valid = read & status_cs;
    assign data_out       = data_out_valid ? {28'd0, overrun, timeout, ack_error, tx_active} : '0;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the captured line values and status words are compared with hand-computed tables.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 50;
    localparam int H   = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0, write = 1'b0, data_cs = 1'b0, status_cs = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_out_valid, tx_active;
    wire         ps2_clock, ps2_data;
    logic        dev_clk_low = 1'b0, dev_data_low = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    assign ps2_clock = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data  = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clock);
    pullup (ps2_data);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .read(read),
        .write(write),
        .data_cs(data_cs),
        .status_cs(status_cs),
        .data_in(data_in),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .tx_active(tx_active),
        .ps2_clock(ps2_clock),
        .ps2_data(ps2_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] din;
        bit          ack;
        logic [10:0] frame;   // {stop, parity, data[7:0], start}
        logic [31:0] status;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ps2_clock;
            1:       return ps2_data;
            default: return tx_active;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic lvl, input int bound,
                              output int waited, output bit ok);
        waited = 0;
        while (sig(sel) !== lvl && waited < bound) begin
            @(negedge clock);
            waited++;
        end
        ok = (sig(sel) === lvl);
    endtask

    task automatic do_write(input logic [31:0] d, input bit rd_same);
        @(negedge clock);
        write = 1'b1; data_cs = 1'b1; data_in = d;
        if (rd_same) begin
            read = 1'b1; status_cs = 1'b1;
            #1 check("busy_on_start_cycle", data_out, 32'h0);
        end
        @(negedge clock);
        write = 1'b0; data_cs = 1'b0; read = 1'b0; status_cs = 1'b0;
    endtask

    task automatic read_status(output logic [31:0] s);
        @(negedge clock);
        read = 1'b1; status_cs = 1'b1;
        #1 s = data_out;
        read = 1'b0; status_cs = 1'b0;
    endtask

    task automatic dev_pulse();
        dev_clk_low = 1'b1;
        tick(H);
        dev_clk_low = 1'b0;
        tick(H);
    endtask

    task automatic run_frame(input bit ack, output logic [10:0] bits, output int inh,
                             output bit busy_ok);
        int w;
        bit ok;
        busy_ok = 1'b1;
        bits    = '0;
        wait_level(0, 1'b0, 10, w, ok);
        check("inhibit_seen", 32'(ok), 32'd1);
        wait_level(0, 1'b1, 1000, inh, ok);
        check("clock_released", 32'(ok), 32'd1);
        tick(H);
        bits[0] = ps2_data;
        busy_ok &= tx_active;
        for (int i = 1; i <= 10; i++) begin
            dev_pulse();
            bits[i] = ps2_data;
            busy_ok &= tx_active;
        end
        dev_data_low = ack;
        tick(2);
        dev_clk_low = 1'b1;
        tick(H);
        busy_ok &= tx_active;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        wait_level(2, 1'b0, 20, w, ok);
        check("return_to_idle", 32'(ok), 32'd1);
    endtask

    task automatic run_vector(input vec_t v, input int idx, input bit rd_same);
        logic [10:0] bits;
        logic [31:0] s;
        int          inh;
        bit          busy_ok;
        do_write(v.din, rd_same);
        run_frame(v.ack, bits, inh, busy_ok);
        check($sformatf("v%0d_inhibit_len_ok", idx), 32'(inh >= INH), 32'd1);
        check($sformatf("v%0d_frame", idx), 32'(bits), 32'(v.frame));
        check($sformatf("v%0d_busy_throughout", idx), 32'(busy_ok), 32'd1);
        read_status(s);
        check($sformatf("v%0d_status", idx), s, v.status);
    endtask

    initial begin
        logic [10:0] bits;
        logic [31:0] s;
        int          inh, w, n_bad;
        bit          busy_ok, ok;

        vecs[0] = '{32'h0000_00ED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 32'h0};
        vecs[1] = '{32'h0000_0007, 1'b1, {1'b1, 1'b0, 8'h07, 1'b0}, 32'h0};
        vecs[2] = '{32'h0000_0000, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 32'h0};
        vecs[3] = '{32'h0000_01FF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 32'h0};
        vecs[4] = '{32'h0000_0012, 1'b0, {1'b1, 1'b1, 8'h12, 1'b0}, 32'h2};
        vecs[5] = '{32'h0000_00F4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 32'h0};

        tick(3);
        check("reset_tx_active", 32'(tx_active), 32'd0);
        check("reset_clock_line", 32'(ps2_clock), 32'd1);
        check("reset_data_line", 32'(ps2_data), 32'd1);
        reset = 1'b0;
        read_status(s);
        check("reset_status", s, 32'h0);
        @(negedge clock);
        read = 1'b1;
        #1 check("valid_needs_cs", 32'(data_out_valid), 32'd0);
        read = 1'b0;

        for (int i = 0; i < 6; i++) run_vector(vecs[i], i, i == 0);

        // Overrun: second write lands mid-frame and must be dropped.
        do_write(32'h55, 1'b0);
        fork
            run_frame(1'b1, bits, inh, busy_ok);
            begin
                tick(60);
                do_write(32'hAA, 1'b0);
            end
        join
        check("overrun_frame", 32'(bits), 32'({1'b1, 1'b1, 8'h55, 1'b0}));
        read_status(s);
        check("overrun_status", s, 32'h8);
        n_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ps2_clock !== 1'b1 || tx_active !== 1'b0) n_bad++;
        end
        check("no_second_frame", 32'(n_bad), 32'd0);

        // Timeout: device never clocks after release.
        do_write(32'h3C, 1'b0);
        wait_level(0, 1'b0, 10, w, ok);
        wait_level(0, 1'b1, 100, w, ok);
        check("timeout_clock_released", 32'(ok), 32'd1);
        wait_level(1, 1'b1, 60, w, ok);
        check("timeout_release_within_51", 32'(ok && w <= 51), 32'd1);
        check("timeout_clock_line", 32'(ps2_clock), 32'd1);
        check("timeout_tx_active", 32'(tx_active), 32'd0);
        read_status(s);
        check("timeout_status", s, 32'h4);

        // Reset while the parity bit (0 for 0x01) is on the line.
        do_write(32'h01, 1'b0);
        wait_level(0, 1'b0, 10, w, ok);
        wait_level(0, 1'b1, 100, w, ok);
        tick(H);
        for (int i = 0; i < 8; i++) dev_pulse();
        dev_clk_low = 1'b1;
        tick(H);
        dev_clk_low = 1'b0;
        tick(2);
        check("parity_bit_driven", 32'(ps2_data), 32'd0);
        reset = 1'b1;
        #1;
        check("async_reset_data_line", 32'(ps2_data), 32'd1);
        check("async_reset_clock_line", 32'(ps2_clock), 32'd1);
        check("async_reset_tx_active", 32'(tx_active), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        read_status(s);
        check("post_reset_status", s, 32'h0);
        run_vector(vecs[0], 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
